// File: rtl/dqsw_wrlvl_sweep_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dqsw_wrlvl_sweep_ctrl
//
// Write-leveling sweep controller for one DQSW training lane. Starting from
// tap 0 it steps the lane IOD dynamic delay line one tap at a time. At each
// tap it waits for the line to settle, then takes a burst of RX_DATA samples.
// It reports the first tap where the feedback goes stable-0 -> stable-1, which
// is the point where DQS aligns with the CK edge. All logic runs on the rising
// edge of FAB_CLK.
//
// Ports
//   FAB_CLK                    in   fabric clock
//   ARST_N                     in   asynchronous active-low reset
//   START                      in   1-cycle sweep request (ignored while BUSY)
//   BUSY                       out  sweep in progress
//   DONE                       out  edge found; held until the next START
//   FAIL                       out  no edge found; held until the next START
//   EDGE_TAP                   out  tap of the detected edge, valid while DONE
//   TAP_COUNT                  out  current delay-line tap
//   RX_DATA_0                  in   IOD deserialised feedback sample pair
//   DELAY_LINE_OUT_OF_RANGE_0  in   IOD delay-line range flag
//   DELAY_LINE_LOAD_0          out  1-cycle pulse that reloads the line to tap 0
//   DELAY_LINE_MOVE_0          out  1-cycle step pulse
//   DELAY_LINE_DIRECTION_0     out  step direction, 1 = increment
//   EYE_MONITOR_CLEAR_FLAGS_0  out  1-cycle clear, coincident with LOAD
// -----------------------------------------------------------------------------
module dqsw_wrlvl_sweep_ctrl #(
    parameter int MAX_TAPS      = 128,
    parameter int TAP_W         = 7,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_COUNT  = 4
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic             FAIL,
    output logic [TAP_W-1:0] EDGE_TAP,
    output logic [TAP_W-1:0] TAP_COUNT,
    input  logic [1:0]       RX_DATA_0,
    input  logic             DELAY_LINE_OUT_OF_RANGE_0,
    output logic             DELAY_LINE_LOAD_0,
    output logic             DELAY_LINE_MOVE_0,
    output logic             DELAY_LINE_DIRECTION_0,
    output logic             EYE_MONITOR_CLEAR_FLAGS_0
);

    // The phase counter times both SETTLE and SAMPLE, so it is sized for the
    // longer of the two.
    localparam int PH_MAX = (SETTLE_CYCLES > SAMPLE_COUNT) ? SETTLE_CYCLES : SAMPLE_COUNT;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int SC_W   = $clog2(SAMPLE_COUNT + 1);

    localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [PH_W-1:0]  SAMPLE_LAST = PH_W'(SAMPLE_COUNT - 1);
    localparam logic [SC_W-1:0]  SAMPLE_ALL  = SC_W'(SAMPLE_COUNT);
    localparam logic [TAP_W-1:0] TAP_LAST    = TAP_W'(MAX_TAPS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_MOVE,
        ST_DONE,
        ST_FAIL
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PH_W-1:0]  phase_cnt;
    logic [SC_W-1:0]  ones_cnt;
    logic [SC_W-1:0]  zeros_cnt;
    logic             seen_zero;
    logic [TAP_W-1:0] tap_q;
    logic [TAP_W-1:0] edge_q;

    // Per-tap verdict, meaningful only in EVAL when the sample burst is complete.
    logic tap_one;
    logic tap_zero;

    assign tap_one  = (ones_cnt  == SAMPLE_ALL);
    assign tap_zero = (zeros_cnt == SAMPLE_ALL);

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d                   = state_q;
        BUSY                      = 1'b0;
        DONE                      = 1'b0;
        FAIL                      = 1'b0;
        DELAY_LINE_LOAD_0         = 1'b0;
        DELAY_LINE_MOVE_0         = 1'b0;
        DELAY_LINE_DIRECTION_0    = 1'b0;
        EYE_MONITOR_CLEAR_FLAGS_0 = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                BUSY                      = 1'b1;
                DELAY_LINE_LOAD_0         = 1'b1;
                DELAY_LINE_DIRECTION_0    = 1'b1;
                EYE_MONITOR_CLEAR_FLAGS_0 = 1'b1;
                state_d                   = ST_SETTLE;
            end
            ST_SETTLE: begin
                BUSY                   = 1'b1;
                DELAY_LINE_DIRECTION_0 = 1'b1;
                if (phase_cnt == SETTLE_LAST) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                BUSY                   = 1'b1;
                DELAY_LINE_DIRECTION_0 = 1'b1;
                if (phase_cnt == SAMPLE_LAST) state_d = ST_EVAL;
            end
            ST_EVAL: begin
                BUSY                   = 1'b1;
                DELAY_LINE_DIRECTION_0 = 1'b1;
                if (DELAY_LINE_OUT_OF_RANGE_0)  state_d = ST_FAIL;
                else if (tap_one && seen_zero)  state_d = ST_DONE;
                else if (tap_q == TAP_LAST)     state_d = ST_FAIL;
                else                            state_d = ST_MOVE;
            end
            ST_MOVE: begin
                // Direction stays high through MOVE so the IOD sees it stable
                // on both sides of the step pulse.
                BUSY                   = 1'b1;
                DELAY_LINE_MOVE_0      = 1'b1;
                DELAY_LINE_DIRECTION_0 = 1'b1;
                state_d                = ST_SETTLE;
            end
            ST_DONE: begin
                DONE = 1'b1;
                if (START) state_d = ST_LOAD;
            end
            ST_FAIL: begin
                FAIL = 1'b1;
                if (START) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // -------------------------------------------------------------------------
    // Sweep datapath: phase timer, sample tallies, tap tracking
    // -------------------------------------------------------------------------
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            phase_cnt <= '0;
            ones_cnt  <= '0;
            zeros_cnt <= '0;
            seen_zero <= 1'b0;
            tap_q     <= '0;
            edge_q    <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    phase_cnt <= '0;
                    tap_q     <= '0;
                    seen_zero <= 1'b0;
                end
                ST_SETTLE: begin
                    // Tallies are cleared here so each tap starts a fresh burst.
                    ones_cnt  <= '0;
                    zeros_cnt <= '0;
                    if (phase_cnt == SETTLE_LAST) phase_cnt <= '0;
                    else                          phase_cnt <= phase_cnt + 1'b1;
                end
                ST_SAMPLE: begin
                    // Mixed 01/10 samples count toward neither tally, so the
                    // tap can only be judged stable if every sample agrees.
                    if (RX_DATA_0 == 2'b11) ones_cnt  <= ones_cnt + 1'b1;
                    if (RX_DATA_0 == 2'b00) zeros_cnt <= zeros_cnt + 1'b1;
                    if (phase_cnt == SAMPLE_LAST) phase_cnt <= '0;
                    else                          phase_cnt <= phase_cnt + 1'b1;
                end
                ST_EVAL: begin
                    if (tap_zero) seen_zero <= 1'b1;
                    if (!DELAY_LINE_OUT_OF_RANGE_0 && tap_one && seen_zero)
                        edge_q <= tap_q;
                end
                ST_MOVE: begin
                    // EVAL never routes here from the last tap, so this cannot wrap.
                    phase_cnt <= '0;
                    tap_q     <= tap_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign TAP_COUNT = tap_q;
    assign EDGE_TAP  = edge_q;

endmodule

// File: tb/tb_dqsw_wrlvl_sweep_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_dqsw_wrlvl_sweep_ctrl
//
// Directed bench for the write-leveling sweep controller. A small IOD model
// tracks its own delay-line tap from the LOAD/MOVE/DIRECTION pulses. It
// returns a per-scenario feedback pattern for that tap. Expected cycle counts
// follow from a per-tap period of SETTLE+SAMPLE+2 = 14: tap-n EVAL is at cycle
// 14+14n, and DONE/FAIL rise one cycle later.
// -----------------------------------------------------------------------------
module tb_dqsw_wrlvl_sweep_ctrl;

    localparam int TAP_W = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             busy;
    logic             done;
    logic             fail;
    logic [TAP_W-1:0] edge_tap;
    logic [TAP_W-1:0] tap_count;
    logic [1:0]       rx_data;
    logic             oor;
    logic             dl_load;
    logic             dl_move;
    logic             dl_dir;
    logic             clr_flags;

    int  n_checks = 0;
    int  n_fail   = 0;

    // IOD model state, owned by the monitor process.
    int   scenario    = 0;
    int   model_tap   = 0;
    int   total_loads = 0;
    int   total_moves = 0;
    int   excl_err    = 0;
    int   clr_err     = 0;
    logic toggle      = 1'b0;

    always #5 clk = ~clk;

    dqsw_wrlvl_sweep_ctrl #(
        .MAX_TAPS      (128),
        .TAP_W         (TAP_W),
        .SETTLE_CYCLES (8),
        .SAMPLE_COUNT  (4)
    ) dut (
        .FAB_CLK                   (clk),
        .ARST_N                    (rst_n),
        .START                     (start),
        .BUSY                      (busy),
        .DONE                      (done),
        .FAIL                      (fail),
        .EDGE_TAP                  (edge_tap),
        .TAP_COUNT                 (tap_count),
        .RX_DATA_0                 (rx_data),
        .DELAY_LINE_OUT_OF_RANGE_0 (oor),
        .DELAY_LINE_LOAD_0         (dl_load),
        .DELAY_LINE_MOVE_0         (dl_move),
        .DELAY_LINE_DIRECTION_0    (dl_dir),
        .EYE_MONITOR_CLEAR_FLAGS_0 (clr_flags)
    );

    // Feedback pattern per scenario, indexed by the model's own tap.
    always_comb begin
        rx_data = 2'b00;
        case (scenario)
            1: rx_data = (model_tap >= 37) ? 2'b11 : 2'b00;
            2: rx_data = 2'b11;
            3: begin
                if (model_tap < 20)      rx_data = 2'b00;
                else if (model_tap < 23) rx_data = toggle ? 2'b01 : 2'b10;
                else                     rx_data = 2'b11;
            end
            default: rx_data = 2'b00;
        endcase
    end

    assign oor = (scenario == 4) && (model_tap >= 50);

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        toggle <= ~toggle;
        if (dl_load)               model_tap <= 0;
        else if (dl_move && dl_dir) model_tap <= model_tap + 1;
        if (dl_load) total_loads <= total_loads + 1;
        if (dl_move) total_moves <= total_moves + 1;
        if ((32'(busy) + 32'(done) + 32'(fail)) > 1) excl_err <= excl_err + 1;
        if (clr_flags !== dl_load) clr_err <= clr_err + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Pulses START for one cycle (cycle 0) and waits for DONE or FAIL.
    // end_cyc is the first cycle with DONE/FAIL high, -1 on timeout. With spam
    // set, START is re-pulsed periodically while the sweep is running.
    task automatic run_sweep(input int budget, input bit spam,
                             output int end_cyc, output int loads, output int moves);
        int base_l;
        int base_m;
        base_l  = total_loads;
        base_m  = total_moves;
        end_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start = (spam && c < 400 && (c % 9) == 4);
            if (c == 1) check("load_latency", 32'(dl_load), 32'd1);
            if (done || fail) begin
                end_cyc = c;
                break;
            end
        end
        start = 1'b0;
        if (end_cyc < 0) check("sweep_timeout", 32'd0, 32'd1);
        #1;
        loads = total_loads - base_l;
        moves = total_moves - base_m;
    endtask

    initial begin
        int ec;
        int nl;
        int nm;
        int snap_l;
        int snap_m;
        bit hit;

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_fail",  32'(fail),      32'd0);
        check("rst_tap",   32'(tap_count), 32'd0);
        check("rst_edge",  32'(edge_tap),  32'd0);
        check("rst_load",  32'(dl_load),   32'd0);
        check("rst_move",  32'(dl_move),   32'd0);
        check("rst_dir",   32'(dl_dir),    32'd0);
        check("rst_clr",   32'(clr_flags), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Edge at tap 37: EVAL at 14+37*14 = 532, DONE at 533.
        scenario = 1;
        run_sweep(3000, 1'b0, ec, nl, nm);
        check("s1_done_cycle", 32'(ec),        32'd533);
        check("s1_done",       32'(done),      32'd1);
        check("s1_fail",       32'(fail),      32'd0);
        check("s1_busy",       32'(busy),      32'd0);
        check("s1_edge_tap",   32'(edge_tap),  32'd37);
        check("s1_tap_count",  32'(tap_count), 32'd37);
        check("s1_loads",      32'(nl),        32'd1);
        check("s1_moves",      32'(nm),        32'd37);

        // Always 1: no preceding stable zero, FAIL after the tap-127 EVAL (1792).
        scenario = 2;
        run_sweep(3000, 1'b0, ec, nl, nm);
        check("s2_fail_cycle", 32'(ec),        32'd1793);
        check("s2_fail",       32'(fail),      32'd1);
        check("s2_done",       32'(done),      32'd0);
        check("s2_tap_count",  32'(tap_count), 32'd127);
        check("s2_moves",      32'(nm),        32'd127);

        // Unstable taps 20-22 skipped; edge at 23: DONE at 14+23*14+1 = 337.
        scenario = 3;
        run_sweep(3000, 1'b0, ec, nl, nm);
        check("s3_done_cycle", 32'(ec),        32'd337);
        check("s3_done",       32'(done),      32'd1);
        check("s3_edge_tap",   32'(edge_tap),  32'd23);

        // Out-of-range at tap 50: FAIL at 14+50*14+1 = 715, no further steps.
        scenario = 4;
        run_sweep(3000, 1'b0, ec, nl, nm);
        check("s4_fail_cycle", 32'(ec),        32'd715);
        check("s4_fail",       32'(fail),      32'd1);
        check("s4_done",       32'(done),      32'd0);
        check("s4_tap_count",  32'(tap_count), 32'd50);
        check("s4_moves",      32'(nm),        32'd50);
        snap_m = total_moves;
        repeat (30) @(negedge clk);
        #1;
        check("s4_no_more_moves", 32'(total_moves - snap_m), 32'd0);
        check("s4_fail_held",     32'(fail),                 32'd1);

        // Asynchronous reset mid-sweep once the line reaches tap 30.
        scenario = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (model_tap == 30) begin
                hit = 1'b1;
                break;
            end
        end
        check("s5_reached_tap30", 32'(hit), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("s5_busy",  32'(busy),      32'd0);
        check("s5_done",  32'(done),      32'd0);
        check("s5_fail",  32'(fail),      32'd0);
        check("s5_tap",   32'(tap_count), 32'd0);
        check("s5_edge",  32'(edge_tap),  32'd0);
        check("s5_load",  32'(dl_load),   32'd0);
        check("s5_move",  32'(dl_move),   32'd0);
        check("s5_dir",   32'(dl_dir),    32'd0);
        check("s5_clr",   32'(clr_flags), 32'd0);
        snap_l = total_loads;
        snap_m = total_moves;
        repeat (3) @(negedge clk);
        #1;
        check("s5_no_pulses", 32'(total_loads - snap_l + total_moves - snap_m), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_sweep(3000, 1'b0, ec, nl, nm);
        check("s5_done_cycle", 32'(ec),       32'd533);
        check("s5_edge_tap",   32'(edge_tap), 32'd37);
        check("s5_moves",      32'(nm),       32'd37);

        // START re-pulsed while BUSY must not restart the sweep.
        run_sweep(3000, 1'b1, ec, nl, nm);
        check("s6_done_cycle", 32'(ec),       32'd533);
        check("s6_edge_tap",   32'(edge_tap), 32'd37);
        check("s6_loads",      32'(nl),       32'd1);
        check("s6_moves",      32'(nm),       32'd37);

        repeat (2) @(negedge clk);
        check("exclusive_status", 32'(excl_err), 32'd0);
        check("clear_with_load",  32'(clr_err),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
